// File: rtl/dmem_if.sv
// CPU-side and RAM-side signal bundle for dmem_access_ctrl.
// The controller takes the slave modport; the CPU/RAM environment takes the master modport.
interface dmem_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_read_i;
   logic              cpu_write_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              err_o;

   modport slave (
      input  cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
      output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );

   modport master (
      output cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
      input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-side access controller: stalls the CPU across a req/ack RAM access and returns load data.
// Define DMEM_WBUF_EN to add a posted-write FIFO (WBUF_DEPTH entries) in front of the RAM.
module dmem_access_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
`ifdef DMEM_WBUF_EN
   ,
   parameter int unsigned WBUF_DEPTH = 2
`endif
) (
   input logic   clk_i,
   input logic   rst_i,
   dmem_if.slave bus
);
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              stall, aligned, access, load_only, timeout;

   assign aligned   = (bus.cpu_addr_i[1:0] == 2'b00);
   assign access    = bus.cpu_read_i | bus.cpu_write_i;
   assign load_only = bus.cpu_read_i & ~bus.cpu_write_i;
   assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
   assign timeout   = ~bus.mem_ack_i & (cnt_inc == CntMax);

`ifdef DMEM_WBUF_EN
   localparam int unsigned PtrW  = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
   localparam int unsigned FillW = $clog2(WBUF_DEPTH + 1);

   logic [ADDR_W-1:0] fifo_addr_q [WBUF_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [WBUF_DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [FillW-1:0]  fill_q;
   logic              push, pop, fifo_empty, fifo_full, load_busy;

   assign fifo_empty = (fill_q == '0);
   assign fifo_full  = (fill_q == FillW'(WBUF_DEPTH));
   assign load_busy  = (state_q != StIdle) & ~we_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(WBUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push & ~pop)      fill_q <= fill_q + FillW'(1);
         else if (pop & ~push) fill_q <= fill_q - FillW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.cpu_addr_i;
         fifo_data_q[wr_ptr_q] <= bus.cpu_wdata_i;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
`ifdef DMEM_WBUF_EN
      push    = 1'b0;
      pop     = 1'b0;
`endif
      case (state_q)
         StIdle: begin
`ifdef DMEM_WBUF_EN
            // Draining wins; the head entry is retired only when the RAM is done with it.
            if (!fifo_empty) begin
               state_d = StReq;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = fifo_addr_q[rd_ptr_q];
               wdata_d = fifo_data_q[rd_ptr_q];
               cnt_d   = '0;
            end else if (access & aligned & load_only) begin
               state_d = StReq;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = bus.cpu_addr_i;
               cnt_d   = '0;
            end
`else
            if (access & aligned) begin
               stall   = 1'b1;
               state_d = StReq;
               req_d   = 1'b1;
               we_d    = bus.cpu_write_i;
               addr_d  = bus.cpu_addr_i;
               wdata_d = bus.cpu_wdata_i;
               cnt_d   = '0;
               if (bus.cpu_read_i & bus.cpu_write_i) err_d = 1'b1;
            end else if (access) begin
               err_d = 1'b1;
               if (load_only) rdata_d = '0;
            end
`endif
         end
         StReq: begin
`ifndef DMEM_WBUF_EN
            stall = 1'b1;
`endif
            cnt_d = cnt_inc;
            if (bus.mem_ack_i) begin
               req_d   = 1'b0;
               state_d = StDone;
               if (!we_q) rdata_d = bus.mem_rdata_i;
            end else if (timeout) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StDone;
            end
`ifdef DMEM_WBUF_EN
            pop = we_q & (bus.mem_ack_i | timeout);
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
`ifdef DMEM_WBUF_EN
      // CPU side: stores post into the buffer, loads wait until it has drained.
      if (load_busy) begin
         stall = (state_q == StReq);
      end else if (access) begin
         if (!aligned) begin
            err_d = 1'b1;
            if (load_only) rdata_d = '0;
         end else if (bus.cpu_write_i) begin
            if (bus.cpu_read_i) err_d = 1'b1;
            if (fifo_full & ~pop) stall = 1'b1;
            else push = 1'b1;
         end else begin
            stall = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.cpu_stall_o = stall & ~rst_i;
   assign bus.cpu_rdata_o = rdata_q;
   assign bus.mem_req_o   = req_q;
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.err_o       = err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (TIMEOUT = 4).
module tb_dmem_access_ctrl;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   k;
   logic done;

   dmem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
      bus.cpu_read_i  = rd;
      bus.cpu_write_i = wr;
      bus.cpu_addr_i  = a;
      bus.cpu_wdata_i = d;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      nxt();
      // Reset: pending load must not stall, all outputs cleared
      chk("rst_stall", bus.cpu_stall_o, 0);
      chk("rst_req", bus.mem_req_o, 0);
      chk("rst_we", bus.mem_we_o, 0);
      chk("rst_addr", bus.mem_addr_o, 0);
      chk("rst_wdata", bus.mem_wdata_o, 0);
      chk("rst_rdata", bus.cpu_rdata_o, 0);
      chk("rst_err", bus.err_o, 0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);

      // T1: load 0x10, ack on third REQ cycle
      nxt();
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      chk("t1_idle_stall", bus.cpu_stall_o, 1);
      chk("t1_idle_req", bus.mem_req_o, 0);
      nxt();
      chk("t1_req1", bus.mem_req_o, 1);
      chk("t1_req1_stall", bus.cpu_stall_o, 1);
      chk("t1_addr", bus.mem_addr_o, 32'h10);
      chk("t1_we", bus.mem_we_o, 0);
      nxt();
      chk("t1_req2", bus.mem_req_o, 1);
      chk("t1_req2_stall", bus.cpu_stall_o, 1);
      nxt();
      chk("t1_req3", bus.mem_req_o, 1);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hDEADBEEF;
      #1;
      chk("t1_req3_stall", bus.cpu_stall_o, 1);
      nxt();
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
      #1;
      chk("t1_done_stall", bus.cpu_stall_o, 0);
      chk("t1_done_req", bus.mem_req_o, 0);
      chk("t1_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_no_restart", bus.mem_req_o, 0);
      chk("t1_idle_after", bus.cpu_stall_o, 0);
      // Stray ack in IDLE must be ignored
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h11111111;
      nxt();
      bus.mem_ack_i = 1'b0;
      #1;
      chk("idle_ack_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);
      chk("idle_ack_req", bus.mem_req_o, 0);

`ifndef DMEM_WBUF_EN
      // T2: store 0x20, immediate ack
      nxt();
      drive(1'b0, 1'b1, 32'h20, 32'h12345678);
      chk("t2_idle_stall", bus.cpu_stall_o, 1);
      nxt();
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h0BADF00D;
      #1;
      chk("t2_req", bus.mem_req_o, 1);
      chk("t2_we", bus.mem_we_o, 1);
      chk("t2_addr", bus.mem_addr_o, 32'h20);
      chk("t2_wdata", bus.mem_wdata_o, 32'h12345678);
      chk("t2_req_stall", bus.cpu_stall_o, 1);
      nxt();
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
      #1;
      chk("t2_done_stall", bus.cpu_stall_o, 0);
      chk("t2_done_req", bus.mem_req_o, 0);
      chk("t2_err", bus.err_o, 0);
      chk("t2_rdata_kept", bus.cpu_rdata_o, 32'hDEADBEEF);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
`endif

      // T3: misaligned load 0x22
      nxt();
      drive(1'b1, 1'b0, 32'h22, 32'h0);
      chk("t3_stall", bus.cpu_stall_o, 0);
      chk("t3_req", bus.mem_req_o, 0);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_err", bus.err_o, 1);
      chk("t3_req_after", bus.mem_req_o, 0);
      chk("t3_rdata", bus.cpu_rdata_o, 0);

      // Reset clears the sticky error
      rst = 1'b1;
      #1;
      chk("rst2_err", bus.err_o, 0);
      nxt();
      rst = 1'b0;

      // Plain load so rdata is non-zero before the timeout case
      nxt();
      drive(1'b1, 1'b0, 32'h14, 32'h0);
      nxt();
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hCAFEF00D;
      #1;
      chk("ld14_addr", bus.mem_addr_o, 32'h14);
      nxt();
      bus.mem_ack_i = 1'b0;
      #1;
      chk("ld14_rdata", bus.cpu_rdata_o, 32'hCAFEF00D);
      chk("ld14_err", bus.err_o, 0);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);

      // T4: load 0x30 with no ack, TIMEOUT = 4
      nxt();
      drive(1'b1, 1'b0, 32'h30, 32'h0);
      chk("t4_idle_stall", bus.cpu_stall_o, 1);
      for (int i = 0; i < 4; i++) begin
         nxt();
         chk("t4_req_hold", bus.mem_req_o, 1);
         chk("t4_stall_hold", bus.cpu_stall_o, 1);
      end
      chk("t4_err_before", bus.err_o, 0);
      nxt();
      chk("t4_done_req", bus.mem_req_o, 0);
      chk("t4_err", bus.err_o, 1);
      chk("t4_rdata", bus.cpu_rdata_o, 0);
      chk("t4_done_stall", bus.cpu_stall_o, 0);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t4_idle_req", bus.mem_req_o, 0);

      // T5: reset pulse mid-REQ, then a normal load to 0x10
      nxt();
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      chk("t5_idle_stall", bus.cpu_stall_o, 1);
      nxt();
      chk("t5_req", bus.mem_req_o, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_req", bus.mem_req_o, 0);
      chk("t5_rst_stall", bus.cpu_stall_o, 0);
      chk("t5_rst_err", bus.err_o, 0);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_back_idle", bus.cpu_stall_o, 1);
      bus.cpu_addr_i = 32'h10;
      nxt();
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h5A5AA5A5;
      #1;
      chk("t5_addr", bus.mem_addr_o, 32'h10);
      chk("t5_req2", bus.mem_req_o, 1);
      nxt();
      bus.mem_ack_i = 1'b0;
      #1;
      chk("t5_rdata", bus.cpu_rdata_o, 32'h5A5AA5A5);
      chk("t5_stall", bus.cpu_stall_o, 0);
      chk("t5_err", bus.err_o, 0);
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef DMEM_WBUF_EN
      // T6: posted stores 0x0/0x4/0x8 with ack withheld, then a load
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      nxt();
      drive(1'b0, 1'b1, 32'h0, 32'hA0);
      chk("t6_st0_stall", bus.cpu_stall_o, 0);
      nxt();
      drive(1'b0, 1'b1, 32'h4, 32'hA1);
      chk("t6_st1_stall", bus.cpu_stall_o, 0);
      nxt();
      drive(1'b0, 1'b1, 32'h8, 32'hA2);
      chk("t6_st2_stall", bus.cpu_stall_o, 1);
      chk("t6_drain0_addr", bus.mem_addr_o, 32'h0);
      chk("t6_drain0_we", bus.mem_we_o, 1);
      nxt();
      chk("t6_st2_wait", bus.cpu_stall_o, 1);
      bus.mem_ack_i = 1'b1;
      #1;
      chk("t6_st2_release", bus.cpu_stall_o, 0);
      nxt();
      bus.mem_ack_i = 1'b0;
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      chk("t6_ld_stall", bus.cpu_stall_o, 1);
      k    = 1;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (bus.mem_req_o && bus.mem_we_o) begin
            chk("t6_drain_order", bus.mem_addr_o, 32'(4 * k));
            bus.mem_ack_i = 1'b1;
            k++;
         end else if (bus.mem_req_o) begin
            chk("t6_load_after_drain", 32'(k), 32'd3);
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = 32'h00000077;
         end
         nxt();
         bus.mem_ack_i = 1'b0;
         #1;
         done = !bus.cpu_stall_o;
      end
      chk("t6_load_done", done, 1);
      chk("t6_rdata", bus.cpu_rdata_o, 32'h00000077);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
